sr_frame_sched: RTL and testbench

//  Shares one DEPTH-stage serial shift-register datapath (data_in/enable/data_out) between two

---
 rtl/sr_frame_sched_pkg.sv | 5 +
 rtl/sr_frame_sched_if.sv | 17 +
 rtl/sr_frame_sched_arb.sv | 22 ++
 rtl/sr_frame_sched.sv | 82 ++++++++
 tb/tb_sr_frame_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_frame_sched_pkg.sv
// Shared types for the shift-register frame scheduler.
package sr_ctrl_pkg;
   localparam int N_REQ = 2;
   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} sr_state_e;
endpackage

// File: rtl/sr_frame_sched_if.sv
// Requester, shift-register and bit-stream signals of the frame scheduler.
interface sr_frame_sched_if #(parameter int WIDTH = 8);
   logic [sr_ctrl_pkg::N_REQ-1:0]       req_valid;
   logic [sr_ctrl_pkg::N_REQ*WIDTH-1:0] req_data;
   logic [sr_ctrl_pkg::N_REQ-1:0]       req_ready;
   logic abort;
   logic sr_data_in, sr_enable, sr_clear, sr_data_out;
   logic bit_valid, bit_data, bit_last, bit_ready;
   logic grant_id, busy;

   modport master (output req_valid, req_data, abort, bit_ready, sr_data_out,
                   input  req_ready, sr_data_in, sr_enable, sr_clear,
                          bit_valid, bit_data, bit_last, grant_id, busy);
   modport slave  (input  req_valid, req_data, abort, bit_ready, sr_data_out,
                   output req_ready, sr_data_in, sr_enable, sr_clear,
                          bit_valid, bit_data, bit_last, grant_id, busy);
endinterface

// File: rtl/sr_frame_sched_arb.sv
// Two-way round-robin arbiter; owns the priority pointer.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   output logic [1:0] o_gnt
);
   logic r_ptr;

   always_comb begin
      o_gnt = '0;
      if (i_req[r_ptr])       o_gnt[r_ptr]  = 1'b1;
      else if (i_req[~r_ptr]) o_gnt[~r_ptr] = 1'b1;
   end

   // The winner loses priority for the next grant.
   always_ff @(posedge clk) begin
      if (reset)      r_ptr <= 1'b0;
      else if (i_upd) r_ptr <= ~o_gnt[1];
   end
endmodule

// File: rtl/sr_frame_sched.sv
// Arbitrates two word requesters onto one serial shift register and streams
// the emerging bits out on a valid/ready interface.
module sr_frame_sched
   import sr_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   sr_frame_sched_if.slave  bus
);
   localparam int EW = $clog2(WIDTH + DEPTH);
   localparam logic [EW-1:0] C_DEPTH = EW'(DEPTH);
   localparam logic [EW-1:0] C_WLAST = EW'(WIDTH - 1);
   localparam logic [EW-1:0] C_LAST  = EW'(WIDTH + DEPTH - 1);

   sr_state_e        r_state, w_nxt;
   logic [EW-1:0]    r_ecnt;
   logic [WIDTH-1:0] r_word;
   logic             r_gid;
   logic [1:0]       w_gnt;
   logic             w_run, w_idle, w_valid, w_last, w_stall, w_en, w_xfer;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .i_req (bus.req_valid),
      .i_upd (w_xfer),
      .o_gnt (w_gnt)
   );

   always_comb begin
      w_run   = ~reset & ~bus.abort;
      w_idle  = (r_state == IDLE);
      w_valid = w_run & ~w_idle & (r_ecnt >= C_DEPTH);
      w_last  = w_valid & (r_ecnt == C_LAST);
      w_stall = w_valid & ~bus.bit_ready;
      w_en    = w_run & ~w_idle & ~w_stall;
      w_xfer  = w_run & w_idle & (|bus.req_valid);
      w_nxt   = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_nxt = SHIFT;
         SHIFT:   if (w_en && r_ecnt == C_WLAST) w_nxt = FLUSH;
         FLUSH:   if (w_en && w_last) w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
      if (bus.abort) w_nxt = IDLE;
   end

   // ecnt saturates at the last bit; the frame leaves FLUSH on that edge anyway.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ecnt  <= '0;
         r_word  <= '0;
         r_gid   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (bus.abort) begin
            r_ecnt <= '0;
         end else if (w_xfer) begin
            r_word <= w_gnt[1] ? bus.req_data[2*WIDTH-1:WIDTH] : bus.req_data[WIDTH-1:0];
            r_gid  <= w_gnt[1];
            r_ecnt <= '0;
         end else if (w_en) begin
            r_word <= r_word << 1;
            if (r_ecnt != C_LAST) r_ecnt <= r_ecnt + 1'b1;
         end
      end
   end

   assign bus.req_ready  = (w_run & w_idle) ? w_gnt : 2'b00;
   assign bus.sr_data_in = w_run & (r_state == SHIFT) & r_word[WIDTH-1];
   assign bus.sr_enable  = w_en;
   assign bus.sr_clear   = reset | bus.abort;
   assign bus.bit_valid  = w_valid;
   assign bus.bit_data   = bus.sr_data_out;
   assign bus.bit_last   = w_last;
   assign bus.grant_id   = r_gid;
   assign bus.busy       = ~w_idle;
endmodule

// File: tb/tb_sr_frame_sched.sv
// Randomised and directed bench for sr_frame_sched with a frame-level reference model.
module tb_sr_frame_sched;
   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   sr_frame_sched_if #(.WIDTH(W)) b8();
   sr_frame_sched_if #(.WIDTH(2)) b2();

   sr_frame_sched #(.WIDTH(W), .DEPTH(D)) dut  (.clk(clk), .reset(reset), .bus(b8));
   sr_frame_sched #(.WIDTH(2), .DEPTH(4)) dut2 (.clk(clk), .reset(reset), .bus(b2));

   // Behavioural shift registers standing in for the driven instances.
   logic [D-1:0] sr8;
   logic [3:0]   sr2;
   always @(posedge clk) begin
      if (b8.sr_clear)       sr8 <= '0;
      else if (b8.sr_enable) sr8 <= {sr8[D-2:0], b8.sr_data_in};
      if (b2.sr_clear)       sr2 <= '0;
      else if (b2.sr_enable) sr2 <= {sr2[2:0], b2.sr_data_in};
   end
   assign b8.sr_data_out = sr8[D-1];
   assign b2.sr_data_out = sr2[3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [1:0] v, input bit p);
      if (v[p])  return int'(p);
      if (v[!p]) return int'(!p);
      return -1;
   endfunction

   // Reference model: frame position n = enable edges taken, full word kept intact.
   bit         m_armed = 0, m_busy = 0, m_gid = 0, m_ptr = 0;
   int         m_n = 0;
   logic [W-1:0] m_word = '0;

   always @(posedge clk) begin
      int w;
      if (reset) begin
         m_busy = 0; m_n = 0; m_gid = 0; m_ptr = 0; m_armed = 1;
      end else if (b8.abort) begin
         m_busy = 0; m_n = 0;
      end else if (!m_busy) begin
         w = pick(b8.req_valid, m_ptr);
         if (w >= 0) begin
            m_word = (w == 1) ? b8.req_data[2*W-1:W] : b8.req_data[W-1:0];
            m_gid = (w == 1); m_ptr = (w == 0); m_n = 0; m_busy = 1;
         end
      end else if (!(m_n >= D && !b8.bit_ready)) begin
         if (m_n == W + D - 1) m_busy = 0;
         else m_n++;
      end
   end

   always @(negedge clk) begin
      bit ev, el, een, stall;
      int w;
      logic [1:0] erdy;
      if (m_armed) begin
         if (reset) begin
            chk("reset_outs", {b8.sr_clear, b8.req_ready, b8.sr_enable, b8.bit_valid, b8.bit_last},
                6'b100000);
         end else begin
            ev    = m_busy && m_n >= D && !b8.abort;
            el    = ev && m_n == W + D - 1;
            stall = ev && !b8.bit_ready;
            een   = m_busy && !b8.abort && !stall;
            erdy  = 2'b00;
            w     = pick(b8.req_valid, m_ptr);
            if (!m_busy && !b8.abort && w >= 0) erdy[w] = 1'b1;
            chk("model_outs",
                {b8.sr_clear, b8.req_ready, b8.sr_enable, b8.bit_valid, b8.bit_last, b8.grant_id, b8.busy},
                {b8.abort, erdy, een, ev, el, m_gid, m_busy});
            if (een) chk("model_sr_in", b8.sr_data_in, (m_n < W) ? m_word[W-1-m_n] : 1'b0);
            if (ev)  chk("model_bit", b8.bit_data, m_word[W-1-(m_n-D)]);
         end
      end
   end

   // Entered at a negedge; returns just after the accepting posedge.
   task automatic accept8(output int g, output logic [W-1:0] w);
      bit got = 0;
      g = 0; w = '0;
      for (int k = 0; k < 40; k++) begin
         if (|b8.req_ready) begin
            got = 1; g = int'(b8.req_ready[1]);
            w = b8.req_ready[1] ? b8.req_data[2*W-1:W] : b8.req_data[W-1:0];
            break;
         end
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("accept_seen", got, 1);
      @(posedge clk); #1;
   endtask

   // Entered just after the accepting posedge; returns at the negedge of the first idle cycle.
   task automatic run8(input int stall_at, input int stall_len, input int abort_cyc,
                       output int fv, output int lc, output int ic, output int nb,
                       output int st, output int ens, output logic [W-1:0] wd);
      fv = 0; lc = 0; ic = 0; nb = 0; st = 0; ens = 0; wd = '0;
      for (int c = 1; c <= 60; c++) begin
         b8.bit_ready = !(nb == stall_at && st < stall_len);
         b8.abort     = (c == abort_cyc);
         @(negedge clk);
         if (c == abort_cyc) begin
            chk("abort_clear", b8.sr_clear, 1);
            chk("abort_novalid", b8.bit_valid, 0);
         end
         if (b8.bit_valid && fv == 0) fv = c;
         if (b8.bit_valid && !b8.bit_ready) begin st++; ens += int'(b8.sr_enable); end
         if (b8.bit_valid && b8.bit_ready) begin
            wd = {wd[W-2:0], b8.bit_data}; nb++;
            if (b8.bit_last) lc = c;
         end
         if (!b8.busy) begin ic = c; break; end
         @(posedge clk); #1;
      end
      chk("frame_end", ic != 0, 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int g, fv, lc, ic, nb, st, ens;
      logic [W-1:0] w, wd;
      logic [1:0] wd2;
      reset = 1;
      b8.req_valid = '0; b8.req_data = '0; b8.abort = 0; b8.bit_ready = 1;
      b2.req_valid = '0; b2.req_data = '0; b2.abort = 0; b2.bit_ready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_clear", b8.sr_clear, 1);
      chk("rst_busy", b8.busy, 0);
      chk("rst_gid", b8.grant_id, 0);
      chk("rst_ready", b8.req_ready, 0);

      // Test 1: single word B4.
      @(posedge clk); #1;
      reset = 0; b8.req_valid = 2'b01; b8.req_data = {8'h00, 8'hB4};
      @(negedge clk);
      chk("t1_ready", b8.req_ready, 2'b01);
      accept8(g, w);
      b8.req_valid = '0;
      run8(99, 0, 0, fv, lc, ic, nb, st, ens, wd);
      chk("t1_grant", g, 0);
      chk("t1_first", fv, 5);
      chk("t1_last", lc, 12);
      chk("t1_idle", ic, 13);
      chk("t1_word", wd, 8'hB4);
      chk("t1_nbits", nb, 8);

      // Test 2: both requesters valid from reset alternate.
      @(posedge clk); #1;
      reset = 1; b8.req_valid = 2'b11; b8.req_data = {8'h3C, 8'hA5};
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         accept8(g, w);
         if (i == 3) b8.req_valid = '0;
         run8(99, 0, 0, fv, lc, ic, nb, st, ens, wd);
         chk("t2_grant", g, i % 2);
         chk("t2_word", wd, (i % 2) ? 8'h3C : 8'hA5);
      end

      // Test 3: stall at bit 2 for three cycles.
      @(posedge clk); #1;
      b8.req_valid = 2'b01; b8.req_data = {8'h00, 8'hFF};
      @(negedge clk);
      accept8(g, w);
      b8.req_valid = '0;
      run8(2, 3, 0, fv, lc, ic, nb, st, ens, wd);
      chk("t3_word", wd, 8'hFF);
      chk("t3_nbits", nb, 8);
      chk("t3_stalls", st, 3);
      chk("t3_no_enable", ens, 0);
      chk("t3_idle", ic, 16);

      // Test 4: abort in FLUSH, then the other requester wins.
      @(posedge clk); #1;
      b8.req_valid = 2'b01; b8.req_data = {8'h5A, 8'h96};
      @(negedge clk);
      accept8(g, w);
      b8.req_valid = '0;
      run8(99, 0, 10, fv, lc, ic, nb, st, ens, wd);
      chk("t4_grant", g, 0);
      chk("t4_no_last", lc, 0);
      chk("t4_idle", ic, 11);
      chk("t4_nbits", nb, 5);
      @(posedge clk); #1;
      b8.req_valid = 2'b11;
      @(negedge clk);
      chk("t4_ready_other", b8.req_ready, 2'b10);
      accept8(g, w);
      b8.req_valid = '0;
      run8(99, 0, 0, fv, lc, ic, nb, st, ens, wd);
      chk("t4_grant2", g, 1);
      chk("t4_word2", wd, 8'h5A);

      // Test 6: reset mid-SHIFT.
      @(posedge clk); #1;
      b8.req_valid = 2'b10; b8.req_data = {8'hC3, 8'h00};
      @(negedge clk);
      accept8(g, w);
      b8.req_valid = '0;
      @(negedge clk);
      chk("t6_gid_before", b8.grant_id, 1);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("t6_busy", b8.busy, 0);
      chk("t6_gid", b8.grant_id, 0);
      chk("t6_bv", b8.bit_valid, 0);
      chk("t6_en", b8.sr_enable, 0);
      @(posedge clk); #1;
      b8.req_valid = 2'b10;
      @(negedge clk);
      accept8(g, w);
      b8.req_valid = '0;
      run8(99, 0, 0, fv, lc, ic, nb, st, ens, wd);
      chk("t6_word", wd, 8'hC3);
      chk("t6_idle", ic, 13);

      // Random traffic against the model.
      for (int k = 0; k < 2500; k++) begin
         @(posedge clk); #1;
         b8.req_valid = 2'($urandom_range(0, 3));
         b8.req_data  = 16'($urandom);
         b8.bit_ready = ($urandom_range(0, 3) != 0);
         b8.abort     = ($urandom_range(0, 63) == 0);
         reset        = ($urandom_range(0, 499) == 0);
      end
      @(posedge clk); #1;
      b8.req_valid = '0; b8.abort = 0; b8.bit_ready = 1; reset = 1;
      @(posedge clk); #1;
      reset = 0;

      // Test 5: WIDTH=2 DEPTH=4, bits appear only in FLUSH.
      b2.req_valid = 2'b01; b2.req_data = {2'b00, 2'b10};
      @(negedge clk);
      chk("t5_ready", b2.req_ready, 2'b01);
      @(posedge clk); #1;
      b2.req_valid = '0;
      fv = 0; lc = 0; ic = 0; nb = 0; wd2 = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (b2.bit_valid && fv == 0) fv = c;
         if (b2.bit_valid) begin
            wd2 = {wd2[0], b2.bit_data}; nb++;
            if (b2.bit_last) lc = c;
         end
         if (!b2.busy) begin ic = c; break; end
         @(posedge clk); #1;
      end
      chk("t5_first", fv, 5);
      chk("t5_last", lc, 6);
      chk("t5_bits", wd2, 2'b10);
      chk("t5_nbits", nb, 2);
      chk("t5_idle", ic, 7);

      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
